// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Holds the PC and the IF/ID pipeline register, drives the instruction-memory
// request/acknowledge handshake, parks a word returned during a stall in a
// skid register, and flushes on EX-stage redirects (including redirects that
// land while a memory access is still outstanding).
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets into a sticky FAULT state; otherwise target bits [1:0] are cleared.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        ST_IDLE,   // one idle cycle after reset before the first request
        ST_REQ,    // request out, waiting for / consuming acks
        ST_DROP,   // redirected while an access is outstanding; its word is discarded
        ST_HOLD,   // word arrived during a stall and sits in the skid register
        ST_FAULT   // misaligned redirect trapped; only reset leaves
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;

    // Word offered to IF/ID this cycle (from memory or from the skid register).
    logic        load_fetch;
    logic [31:0] fetch_word;
    logic [31:0] fetch_pc;

    // Redirect target is always word aligned; a misaligned request is either
    // trapped (alignment check enabled) or silently truncated.
    logic [31:0] redir_tgt;
    logic        redir_bad;

    assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_bad   = redirect && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = (state_q == ST_FAULT);
`else
    assign redir_bad   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Next-state logic for the fetch FSM, PC, request address, skid and IF/ID.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        req_d        = req_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        load_fetch   = 1'b0;
        fetch_word   = imem_rdata;
        fetch_pc     = addr_q;

        case (state_q)
            ST_IDLE: begin
                // Late acks from an abandoned access are ignored here.
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
                if (redirect) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end
            end

            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Word belongs to the wrong path: drop it, refetch at target.
                        pc_d   = redir_tgt;
                        addr_d = redir_tgt;
                    end else if (stall) begin
                        // Decode cannot accept: park the word and stop requesting.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = addr_q;
                        pc_d         = addr_q + 32'd4;
                        req_d        = 1'b0;
                        state_d      = ST_HOLD;
                    end else begin
                        load_fetch = 1'b1;
                        fetch_word = imem_rdata;
                        fetch_pc   = addr_q;
                        pc_d       = addr_q + 32'd4;
                        addr_d     = addr_q + 32'd4;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the ack, so only the PC moves.
                    pc_d    = redir_tgt;
                    state_d = ST_DROP;
                end
            end

            ST_DROP: begin
                if (redirect) begin
                    pc_d = redir_tgt;
                end
                if (imem_ack) begin
                    addr_d  = redirect ? redir_tgt : pc_q;
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redir_tgt;
                    addr_d  = redir_tgt;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    load_fetch = 1'b1;
                    fetch_word = skid_instr_q;
                    fetch_pc   = skid_pc_q;
                    addr_d     = pc_q;
                    req_d      = 1'b1;
                    state_d    = ST_REQ;
                end
            end

            ST_FAULT: begin
                req_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        // IF/ID: redirect flushes even under stall; stall holds; otherwise
        // load the fetched word or insert a bubble.
        if (redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (load_fetch) begin
                id_valid_d = 1'b1;
                id_instr_d = fetch_word;
                id_pc_d    = fetch_pc;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end
        end

        // Misaligned redirect overrides everything: abandon any access.
        if (redir_bad && (state_q != ST_FAULT)) begin
            state_d = ST_FAULT;
            req_d   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
// The memory returns word == address after a programmable latency
// (1 = same-cycle ack). Inputs change and outputs are sampled on the
// falling edge; the DUT updates on the rising edge.
// FETCH_ALIGN_CHECK_EN selects the misaligned-redirect fault scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_err    = 0;
    int lat      = 1;
    int wait_cnt = 0;

    fetch_stage dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory model: ack in the lat-th cycle of a request, word equals address.
    always_ff @(posedge clk) begin
        if (!n_rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = imem_req && (wait_cnt >= lat - 1);
    assign imem_rdata = imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        lat         = 1;

        // Reset state
        step(); step();
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_addr",  imem_addr,        32'h0);
        check("rst_valid", 32'(id_valid),    32'd0);
        check("rst_instr", id_instr,         NOP);
        check("rst_pc",    id_pc,            32'h0);
        check("rst_fault", 32'(fetch_fault), 32'd0);

        // Same-cycle memory: first request one cycle after release, then 1/cycle
        n_rst = 1'b1;
        step();
        check("first_req",   32'(imem_req), 32'd1);
        check("first_addr",  imem_addr,     32'h0);
        check("first_valid", 32'(id_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", 32'(id_valid), 32'd1);
            check("stream_pc",    id_pc,         32'(4 * i));
            check("stream_instr", id_instr,      32'(4 * i));
        end
        check("stream_addr", imem_addr, 32'h10);

        // Stall for 4 cycles while the ack for 0x10 arrives
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_req",   32'(imem_req), 32'd0);
            check("stall_valid", 32'(id_valid), 32'd1);
            check("stall_pc",    id_pc,         32'h0C);
        end
        stall = 1'b0;
        step();
        check("skid_valid", 32'(id_valid), 32'd1);
        check("skid_pc",    id_pc,         32'h10);
        check("skid_instr", id_instr,      32'h10);
        check("skid_req",   32'(imem_req), 32'd1);
        check("skid_addr",  imem_addr,     32'h14);
        step();
        check("post_skid_pc", id_pc, 32'h14);

        // 3-cycle memory after a fresh reset
        n_rst = 1'b0;
        lat   = 3;
        step();
        n_rst = 1'b1;
        step();
        check("lat_first_addr", imem_addr, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("lat_wait1_addr",  imem_addr,     32'(4 * k));
            check("lat_wait1_valid", 32'(id_valid), 32'd0);
            step();
            check("lat_wait2_addr",  imem_addr,     32'(4 * k));
            check("lat_wait2_valid", 32'(id_valid), 32'd0);
            step();
            check("lat_valid", 32'(id_valid), 32'd1);
            check("lat_pc",    id_pc,         32'(4 * k));
            check("lat_instr", id_instr,      32'(4 * k));
            check("lat_addr",  imem_addr,     32'(4 * k + 4));
        end

        // Redirect to 0x100 while the access to 0x8 is outstanding
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("drop_addr0",  imem_addr,     32'h8);
        check("drop_req0",   32'(imem_req), 32'd1);
        check("drop_valid0", 32'(id_valid), 32'd0);
        check("drop_instr0", id_instr,      NOP);
        step();
        check("drop_addr1",  imem_addr,     32'h8);
        check("drop_valid1", 32'(id_valid), 32'd0);
        step();
        check("drop_addr2",  imem_addr,     32'h100);
        check("drop_valid2", 32'(id_valid), 32'd0);
        check("drop_req2",   32'(imem_req), 32'd1);
        step();
        check("tgt_wait1", 32'(id_valid), 32'd0);
        step();
        check("tgt_wait2", 32'(id_valid), 32'd0);
        step();
        check("tgt_valid", 32'(id_valid), 32'd1);
        check("tgt_pc",    id_pc,         32'h100);
        check("tgt_instr", id_instr,      32'h100);
        check("tgt_addr",  imem_addr,     32'h104);

        // Redirect and stall together, same-cycle memory again
        lat         = 1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        check("rs_valid", 32'(id_valid), 32'd0);
        check("rs_instr", id_instr,      NOP);
        check("rs_addr",  imem_addr,     32'h100);
        step();
        check("rs_next_valid", 32'(id_valid), 32'd1);
        check("rs_next_pc",    id_pc,         32'h100);

`ifndef FETCH_ALIGN_CHECK_EN
        // Misaligned target is truncated to a word address, no fault
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        check("trunc_addr",  imem_addr,        32'h200);
        check("trunc_fault", 32'(fetch_fault), 32'd0);
        check("trunc_valid", 32'(id_valid),    32'd0);
        step();
        check("trunc_pc",    id_pc,    32'h200);
        check("trunc_instr", id_instr, 32'h200);
`endif

        // PC wraps modulo 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pc0",   id_pc,     32'hFFFF_FFFC);
        check("wrap_addr1", imem_addr, 32'h0);
        step();
        check("wrap_pc1",    id_pc,         32'h0);
        check("wrap_valid1", 32'(id_valid), 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect traps; only reset recovers
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("fault_flag",  32'(fetch_fault), 32'd1);
            check("fault_req",   32'(imem_req),    32'd0);
            check("fault_valid", 32'(id_valid),    32'd0);
            step();
        end
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        check("fault_clr",      32'(fetch_fault), 32'd0);
        check("fault_rst_addr", imem_addr,        32'h0);
        step();
        check("fault_restart_req",  32'(imem_req), 32'd1);
        check("fault_restart_addr", imem_addr,     32'h0);
        step();
        check("fault_restart_pc",    id_pc,         32'h0);
        check("fault_restart_valid", 32'(id_valid), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with PC register and IF/ID pipeline register for the single-issue RV32I core. Drives the instruction-memory request/acknowledge handshake, captures the returned word, and presents `id_instr`/`id_pc` to the decode stage, whose immediate generator and decoder consume `id_instr` directly. Handles hazard-unit stalls, EX-stage redirects (branches/jumps), and redirects that arrive while a memory access is still outstanding.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `NOP_INSTR`, 32'h0000_0013, bubble word (`addi x0,x0,0`)
- `clk`  in  1  clock; all state updates on rising edge
- `n_rst`  in  1  reset, synchronous, active-low
- `stall`  in  1  hazard unit: hold IF/ID and PC
- `redirect`  in  1  EX: taken branch/jump this cycle
- `redirect_pc`  in  32  redirect target
- `imem_req`  out  1  memory request
- `imem_addr`  out  32  request address (registered)
- `imem_ack`  in  1  `imem_rdata` valid this cycle; may arrive in the request cycle or later
- `imem_rdata`  in  32  fetched word
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_instr`  out  32  IF/ID instruction
- `id_pc`  out  32  PC of `id_instr`
- `fetch_fault`  out  1  misaligned redirect (see Configuration)

## Operation
- Registers: `pc`, `imem_addr`, skid word `skid_instr`/`skid_pc`, IF/ID (`id_valid`, `id_instr`, `id_pc`), state.
- States: IDLE, REQ, DROP, HOLD, FAULT.
- IDLE: `imem_req`=0; next REQ with `imem_addr`=`pc`.
- REQ: `imem_req`=1, address held stable until ack.
  - ack & redirect: discard word; `pc`/`imem_addr`=`redirect_pc`; stay REQ.
  - ack & stall: word/PC into skid; `pc`+=4; go HOLD.
  - ack otherwise: word into IF/ID (`id_valid`=1); `pc`/`imem_addr`+=4; stay REQ.
  - no ack & redirect: `pc`=`redirect_pc`; go DROP (`imem_addr` unchanged).
- DROP: `imem_req`=1 at old address. On ack: discard word; `imem_addr`=`pc`; go REQ. A further redirect updates `pc` only.
- HOLD: `imem_req`=0. On !stall: skid into IF/ID; `imem_addr`=`pc`; go REQ. On redirect: discard skid; `pc`/`imem_addr`=`redirect_pc`; go REQ.
- IF/ID update priority: redirect (any state, even with stall) -> `id_valid`=0, `id_instr`=`NOP_INSTR`; else stall -> hold; else load fetched word if produced, otherwise bubble.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (`n_rst`=0 at edge): state IDLE, `pc`=`imem_addr`=`RESET_PC`, `imem_req`=0, `id_valid`=0, `id_instr`=`NOP_INSTR`, `id_pc`=0, `fetch_fault`=0. Reset mid-transaction abandons it; any late ack is ignored while in IDLE.
- First request: cycle after reset release.
- Latency: ack at edge N -> `id_instr` valid after edge N (one cycle).
- Throughput: one instruction/cycle with same-cycle ack and no stalls.
- `imem_req`/`imem_addr` never change between request and ack.
- Redirect penalty: at least one bubble in ID; plus the outstanding access if in DROP.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 -> go FAULT next edge; `fetch_fault`=1 (sticky), `imem_req`=0, IF/ID flushed to bubble; only reset exits. An outstanding access is abandoned.
- Undefined: `redirect_pc[1:0]` forced to 2'b00; FAULT unreachable; `fetch_fault` tied 0.

## Test plan
- Reset, memory acks same cycle with word = address: `id_pc` 0,4,8,… on consecutive cycles; `id_instr`=`id_pc`; `id_valid`=1 from second cycle after release.
- 3-cycle-latency memory: `imem_addr` stable 3 cycles per fetch; one valid ID instruction per 3 cycles, PCs 0,4,8.
- `stall` high 4 cycles while ack arrives: IF/ID holds, HOLD entered, `imem_req`=0; after release, skid instruction appears next cycle with the correct PC, no duplication or loss.
- `redirect` to 32'h100 while 3-cycle access to 32'h8 outstanding: `imem_addr` stays 8 until ack, word discarded, next request 32'h100; `id_valid`=0 until 32'h100 arrives.
- `redirect` and `stall` together: IF/ID becomes bubble (`NOP_INSTR`, `id_valid`=0); next fetch 32'h100.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 32'h102 -> `fetch_fault`=1, `imem_req`=0 held; `n_rst` pulse clears and fetching restarts at `RESET_PC`.
